// File: rtl/ni_pkg.sv
// Shared types and the 1-of-4 dual-rail encoder for the NI transmitter.
package ni_pkg;

  // Widest flit the encoder handles; each rail carries up to NI_MAX_SCN digits.
  localparam int unsigned NI_MAX_DW  = 64;
  localparam int unsigned NI_MAX_SCN = NI_MAX_DW / 2;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RTZ  = 2'd2
  } state_e;

  // Kind of token currently on (or last on) the rails.
  typedef enum logic [1:0] {
    HEAD = 2'd0,
    DATA = 2'd1,
    EOF  = 2'd2
  } tok_e;

  // Binary to 1-of-4: digit j = bin[2j+1:2j]; value v sets bit j of rail v.
  // Result is {rail3, rail2, rail1, rail0}, each NI_MAX_SCN wide.
  // Digits at or above scn are left all-zero.
  function automatic logic [4*NI_MAX_SCN-1:0] enc_1of4(
    input logic [NI_MAX_DW-1:0] bin,
    input int unsigned          scn
  );
    logic [4*NI_MAX_SCN-1:0] rails;
    rails = '0;
    for (int unsigned j = 0; j < NI_MAX_SCN; j++) begin
      if (j < scn) begin
        case (bin[2*j +: 2])
          2'd0:    rails[j]                = 1'b1;
          2'd1:    rails[NI_MAX_SCN + j]   = 1'b1;
          2'd2:    rails[2*NI_MAX_SCN + j] = 1'b1;
          default: rails[3*NI_MAX_SCN + j] = 1'b1;
        endcase
      end
    end
    return rails;
  endfunction

endpackage

// File: rtl/ni_sync.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module ni_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC-1:0] ff_q;

  // Shift the asynchronous level through SYNC flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[SYNC-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC-1];

endmodule

// File: rtl/ni_tx.sv
// Synchronous-to-asynchronous NI transmitter: buffers binary flits and sends
// them as 1-of-4 dual-rail tokens with a four-phase RTZ handshake, adding an
// EOF token after every tail flit.
// Optional feature macro: NI_TX_HDR_EN (adds dst_x/dst_y and a generated head token).
module ni_tx
  import ni_pkg::*;
#(
  parameter int DW   = 16,
  parameter int SCN  = DW / 2,
  parameter int FD   = 4,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [DW-1:0]  in_data,
  input  logic           in_last,
`ifdef NI_TX_HDR_EN
  input  logic [3:0]     dst_x,
  input  logic [3:0]     dst_y,
`endif
  output logic [SCN-1:0] o0,
  output logic [SCN-1:0] o1,
  output logic [SCN-1:0] o2,
  output logic [SCN-1:0] o3,
  output logic           o4,
  input  logic           ia,
  output logic           busy
);

  localparam int AW = $clog2(FD);
  localparam int SW = $clog2(SYNC + 1);
`ifdef NI_TX_HDR_EN
  localparam int EW = DW + 9;   // {dst_y, dst_x, last, data}
`else
  localparam int EW = DW + 1;   // {last, data}
`endif
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [SW-1:0] SET_ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] SETTLE  = SW'(SYNC);

  // ---------------- input FIFO ----------------
  logic [EW-1:0] mem [FD];
  logic [AW:0]   wr_q, rd_q;
  logic          ready_q;
  logic          empty, full, wr_en, pop;
  logic [EW-1:0] wr_entry, rd_entry;
  logic          rd_last;

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign in_rdy = ready_q & ~full;
  assign wr_en  = in_vld & in_rdy;

`ifdef NI_TX_HDR_EN
  assign wr_entry = {dst_y, dst_x, in_last, in_data};
`else
  assign wr_entry = {in_last, in_data};
`endif

  // FIFO storage; the head entry feeds the rail registers, so the read is
  // registered at the output flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_q[AW-1:0]] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_q[AW-1:0]];
  assign rd_last  = rd_entry[DW];

  // ---------------- acknowledge synchroniser ----------------
  logic ia_s;

  ni_sync #(.SYNC(SYNC)) u_ia_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ia),
    .q_o (ia_s)
  );

  // After reset the synchroniser reads 0 regardless of ia; hold off the FSM
  // until it has had SYNC cycles to reflect the real level.
  logic [SW-1:0] settle_q;
  logic          armed;
  assign armed = (settle_q == SETTLE);

  // FIFO pointers, write-ready flag and post-reset settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      ready_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      ready_q <= 1'b1;
      if (wr_en) wr_q <= wr_q + PTR_ONE;
      if (pop)   rd_q <= rd_q + PTR_ONE;
      if (settle_q != SETTLE) settle_q <= settle_q + SET_ONE;
    end
  end

  // ---------------- encoders ----------------
  logic [NI_MAX_DW-1:0]    ext_data;
  logic [4*NI_MAX_SCN-1:0] enc_data;
`ifdef NI_TX_HDR_EN
  logic [NI_MAX_DW-1:0]    ext_head;
  logic [4*NI_MAX_SCN-1:0] enc_head;
`endif
  logic                    unused_enc;

  // Zero-extend the FIFO head (and destination) to the encoder width.
  always_comb begin
    ext_data           = '0;
    ext_data[DW-1:0]   = rd_entry[DW-1:0];
`ifdef NI_TX_HDR_EN
    ext_head           = '0;
    ext_head[7:0]      = rd_entry[DW+8:DW+1];
`endif
  end

  assign enc_data = enc_1of4(ext_data, SCN);
`ifdef NI_TX_HDR_EN
  assign enc_head = enc_1of4(ext_head, SCN);
  assign unused_enc = ^{enc_data, enc_head};
`else
  assign unused_enc = ^enc_data;
`endif

  // ---------------- handshake FSM ----------------
  state_e         state_q, state_d;
  tok_e           tok_q, tok_d;
  logic           eof_pend_q, eof_pend_d;
  logic           busy_q, busy_d;
  logic [SCN-1:0] o0_q, o0_d, o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
  logic           o4_q, o4_d;
  logic           tok_avail, launch;
`ifdef NI_TX_HDR_EN
  logic           head_done_q, head_done_d;
`endif

  // A pending EOF always counts as available so it goes out before the next frame.
  assign tok_avail = eof_pend_q | ~empty;

  // Next state, token choice (EOF > HEAD > DATA) and next rail values.
  always_comb begin
    state_d    = state_q;
    tok_d      = tok_q;
    eof_pend_d = eof_pend_q;
    busy_d     = busy_q;
    o0_d       = o0_q;
    o1_d       = o1_q;
    o2_d       = o2_q;
    o3_d       = o3_q;
    o4_d       = o4_q;
    pop        = 1'b0;
    launch     = 1'b0;
`ifdef NI_TX_HDR_EN
    head_done_d = head_done_q;
`endif

    case (state_q)
      IDLE: begin
        if (armed && !ia_s && tok_avail) launch = 1'b1;
      end
      SEND: begin
        if (ia_s) begin
          state_d = RTZ;
          o0_d = '0; o1_d = '0; o2_d = '0; o3_d = '0; o4_d = 1'b0;
        end
      end
      RTZ: begin
        if (!ia_s) begin
          // End of the EOF handshake closes the frame; a token issued in the
          // same cycle reopens busy for the next frame.
          if (tok_q == EOF) busy_d = 1'b0;
          if (tok_avail) launch = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        o0_d = '0; o1_d = '0; o2_d = '0; o3_d = '0; o4_d = 1'b0;
      end
    endcase

    if (launch) begin
      state_d = SEND;
      busy_d  = 1'b1;
      if (eof_pend_q) begin
        tok_d      = EOF;
        eof_pend_d = 1'b0;
        o0_d = '0; o1_d = '0; o2_d = '0; o3_d = '0;
        o4_d = 1'b1;
      end
`ifdef NI_TX_HDR_EN
      else if (!head_done_q) begin
        tok_d       = HEAD;
        head_done_d = 1'b1;
        o0_d = enc_head[0            +: SCN];
        o1_d = enc_head[NI_MAX_SCN   +: SCN];
        o2_d = enc_head[2*NI_MAX_SCN +: SCN];
        o3_d = enc_head[3*NI_MAX_SCN +: SCN];
        o4_d = 1'b0;
      end
`endif
      else begin
        tok_d      = DATA;
        pop        = 1'b1;
        eof_pend_d = rd_last;
`ifdef NI_TX_HDR_EN
        if (rd_last) head_done_d = 1'b0;
`endif
        o0_d = enc_data[0            +: SCN];
        o1_d = enc_data[NI_MAX_SCN   +: SCN];
        o2_d = enc_data[2*NI_MAX_SCN +: SCN];
        o3_d = enc_data[3*NI_MAX_SCN +: SCN];
        o4_d = 1'b0;
      end
    end
  end

  // FSM state, token bookkeeping and the rail/busy output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tok_q      <= DATA;
      eof_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      o0_q       <= '0;
      o1_q       <= '0;
      o2_q       <= '0;
      o3_q       <= '0;
      o4_q       <= 1'b0;
`ifdef NI_TX_HDR_EN
      head_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tok_q      <= tok_d;
      eof_pend_q <= eof_pend_d;
      busy_q     <= busy_d;
      o0_q       <= o0_d;
      o1_q       <= o1_d;
      o2_q       <= o2_d;
      o3_q       <= o3_d;
      o4_q       <= o4_d;
`ifdef NI_TX_HDR_EN
      head_done_q <= head_done_d;
`endif
    end
  end

  assign o0   = o0_q;
  assign o1   = o1_q;
  assign o2   = o2_q;
  assign o3   = o3_q;
  assign o4   = o4_q;
  assign busy = busy_q;

endmodule

// File: doc/ni_tx.md
# ni_tx

Synchronous-to-asynchronous network-interface transmitter that feeds the local-port input buffer of an SDM router. It accepts binary flits from a clocked processing element and buffers them. It re-encodes each flit into 1-of-4 dual-rail tokens and drives them with a four-phase return-to-zero handshake, followed by an end-of-frame (EOF) token after every tail flit. The router-side input acknowledge is the only asynchronous input; it is synchronised internally.

## Interface
- DW, 16: flit width in bits; even, at least 8.
- SCN, DW/2: number of 1-of-4 digits per token.
- FD, 4: input FIFO depth in flits; power of 2.
- SYNC, 2: synchroniser stages on `ia`; at least 2.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_vld  in  1  flit valid.
- in_rdy  out  1  FIFO not full; 0 while `rst` is high.
- in_data  in  DW  flit payload.
- in_last  in  1  tail flit of frame.
- dst_x, dst_y  in  4 each  binary destination; only with NI_TX_HDR_EN; sampled with a frame's first flit.
- o0, o1, o2, o3  out  SCN each  1-of-4 rails; digit j = in_data[2j+1:2j], value v drives ov[j].
- o4  out  1  EOF rail.
- ia  in  1  four-phase acknowledge from the router; asynchronous.
- busy  out  1  frame in progress (head sent, EOF not yet completed).

## Operation
- A flit is written to the FIFO on clk when in_vld and in_rdy are both 1. Each FIFO entry holds in_data, in_last and, with the macro, dst.
- FSM states:
  - IDLE: all rails 0.
  - SEND: token driven.
  - RTZ: rails 0, waiting for the acknowledge to fall.
- Token sequence per frame:
  - [head] (macro only)
  - each data flit
  - EOF token: o4=1, o0..o3=0.
- IDLE→SEND when a token is available and ia_s==0. ia_s is `ia` after SYNC flops.
- SEND→RTZ when ia_s==1.
- RTZ→SEND when ia_s==0 and a next token is available; RTZ→IDLE when ia_s==0 and no token is available.
- Each data token pops its flit from the FIFO on the IDLE/RTZ→SEND transition.
- After a token carrying in_last, the next token is always EOF; it is issued before any flit of the next frame.
- All o* outputs come directly from flops. Rails change only between all-zero and valid code, with no intermediate codes.
- In SEND, every digit is exactly one-hot across o0..o3. o4 is 0 for all tokens except EOF.
- A single-flit frame (in_last on the first flit) produces the head (macro only), one data token, then EOF.
- busy sets on the first token of a frame and clears when the EOF handshake reaches RTZ→(IDLE|SEND).

## Timing
- Reset values: o0..o4=0, busy=0, in_rdy=0, FIFO empty, FSM in IDLE.
- Reset asserted mid-handshake clears all outputs asynchronously. No token is resumed after reset.
- After reset release, in_rdy=1 from the next clock edge.
- If `ia` is high at reset release, the block stays in IDLE until ia_s==0.
- Minimum latency from a flit write to the rails valid is 2 cycles, for an empty FIFO in IDLE.
- Rails drop to null 1 cycle after ia_s rises.
- The next token is driven 1 cycle after ia_s falls.
- Token period is at least 2·(SYNC+1) cycles plus the receiver's delay.
- Simultaneous FIFO write and pop in the same cycle is allowed. With the FIFO full, in_rdy=0, and a pop in that cycle does not enable a write until the next cycle.

## Configuration
- NI_TX_HDR_EN defined:
  - A head token is generated before a frame's first flit.
  - Digit0/1 = dst_x[1:0]/dst_x[3:2]; digit2/3 = dst_y[1:0]/dst_y[3:2]; digits 4..SCN-1 = value 0.
  - dst is stored in the FIFO with the first flit.
- NI_TX_HDR_EN undefined:
  - dst_x and dst_y ports are absent.
  - The first flit of each frame is the head and must carry the binary destination in in_data[7:0].

## Structure
- Package ni_pkg contains:
  - a 1-of-4 encode function (DW binary → four SCN-wide rails);
  - the FSM state enum {IDLE, SEND, RTZ};
  - the token-type enum {HEAD, DATA, EOF}.
- Sub-module ni_sync: SYNC-stage flop synchroniser with async reset to 0; used for `ia`.
- The FIFO is inline in ni_tx: pointers of width log2(FD)+1, with full/empty decided by wrap-bit comparison.

## Test plan
- Macro off; frame 0x1B23, 0x00FF(last); responder delay 3 cycles. First token: o0=0x8A, o1=0x40, o2=0x24, o3=0x11, o4=0. Third token: o4=1, o0..o3=0. Exactly 3 tokens.
- Macro on; dst_x=6, dst_y=9. Head token: o0=0xF0, o1=0x06, o2=0x09, o3=0x00. Data tokens follow.
- Macro off; `ia` held low, 6 flits offered. 5 flits are accepted (1 in SEND, 4 in the FIFO), then in_rdy=0. Releasing `ia` drains all flits in order.
- rst pulsed during SEND. o0..o4 are 0 within the same cycle. Output after release comes only from new flits.
- `ia`=1 at reset release with a flit queued. No token is driven until `ia` falls, plus SYNC+1 cycles.
- Two back-to-back 1-flit frames. Token order is D, EOF, D, EOF. busy stays 1 across the gap only if the second frame's first token is issued directly from RTZ.
